// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM stage.
// One load or store is in flight at a time. Each request waits a fixed
// number of cycles, then performs a byte, halfword or word access with
// little-endian lane selection, and reports illegal accesses on err.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (misaligned halfword/word
// accesses report err instead of being forced down to alignment).
//
// Timing: a request accepted at edge A executes at edge A+WAIT_CYCLES+1.
// ready, rd and err are updated at that edge and are visible during the
// following (RESP) cycle. The counter loads WAIT_CYCLES on acceptance and
// counts down in WAIT; the access executes on the WAIT edge at which the
// counter reads zero. Because of that extra execute edge, WAIT_CYCLES=0
// still gives one cycle of latency.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] aluout,
    input  logic [31:0] wd,
    output logic        ready,
    output logic [31:0] rd,
    output logic        err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_memwrite;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic        r_ready;
    logic [31:0] r_rd;
    logic        r_err;

    // Storage is deliberately not reset; contents survive rst.
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [AW-1:0] w_idx;
    logic          w_range_err;
    logic          w_f3_err;
    logic          w_mis_err;
    logic          w_err;
    logic [1:0]    w_off;
    logic [31:0]   w_word;
    logic [31:0]   w_shifted;
    logic [31:0]   w_load;
    logic [3:0]    w_bmask;
    logic [31:0]   w_wd_sh;
    logic [31:0]   w_merged;
    logic          w_exec;
    logic          w_commit;

    assign w_idx       = r_addr[AW+1:2];
    assign w_range_err = ({2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS));

    // The access executes on the WAIT edge where the countdown is exhausted.
    assign w_exec   = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_commit = w_exec && r_memwrite && !w_err;

    // Legal size/sign encodings; unsigned variants exist only for loads.
    always_comb begin
        w_f3_err = 1'b0;
        case (r_funct3)
            3'b000, 3'b001, 3'b010: w_f3_err = 1'b0;
            3'b100, 3'b101:         w_f3_err = r_memwrite;
            default:                w_f3_err = 1'b1;
        endcase
    end

    // Misalignment detection is only present in the checked build.
    always_comb begin
        w_mis_err = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        if (r_funct3[1:0] == 2'b01)
            w_mis_err = r_addr[0];
        else if (r_funct3[1:0] == 2'b10)
            w_mis_err = (r_addr[1:0] != 2'b00);
`endif
    end

    assign w_err = w_f3_err || w_range_err || w_mis_err;

    // Byte offset of the access; halfword and word accesses are forced down
    // to their natural alignment (only relevant when no err is raised).
    always_comb begin
        w_off = 2'b00;
        case (r_funct3[1:0])
            2'b00:   w_off = r_addr[1:0];
            2'b01:   w_off = {r_addr[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

    // Out-of-range words read as zero so the index never leaves the array.
    always_comb begin
        w_word = 32'h0;
        if (!w_range_err)
            w_word = r_mem[w_idx];
    end

    assign w_shifted = w_word >> {w_off, 3'b000};

    // Load extraction with sign or zero extension.
    always_comb begin
        w_load = 32'h0;
        case (r_funct3)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load = w_shifted;
            3'b100:  w_load = {24'h0, w_shifted[7:0]};
            3'b101:  w_load = {16'h0, w_shifted[15:0]};
            default: w_load = 32'h0;
        endcase
    end

    // Store lane enables and the store data moved into those lanes.
    always_comb begin
        w_bmask = 4'b0000;
        case (r_funct3[1:0])
            2'b00:   w_bmask = 4'b0001 << w_off;
            2'b01:   w_bmask = 4'b0011 << w_off;
            2'b10:   w_bmask = 4'b1111;
            default: w_bmask = 4'b0000;
        endcase
    end

    assign w_wd_sh = r_wd << {w_off, 3'b000};

    // Read-modify-write merge: unaddressed lanes keep the old bytes.
    always_comb begin
        w_merged = w_word;
        for (int b = 0; b < 4; b++) begin
            if (w_bmask[b])
                w_merged[b*8 +: 8] = w_wd_sh[b*8 +: 8];
        end
    end

    // Memory write port; a reset at the completion edge suppresses the commit.
    always_ff @(posedge clk) begin
        if (!rst && w_commit)
            r_mem[w_idx] <= w_merged;
    end

    // Request FSM with registered completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_memwrite <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr     <= 32'h0;
            r_wd       <= 32'h0;
            r_ready    <= 1'b0;
            r_rd       <= 32'h0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, RESP: begin
                    r_ready <= 1'b0;
                    if (req) begin
                        r_memwrite <= memwrite;
                        r_funct3   <= funct3;
                        r_addr     <= aluout;
                        r_wd       <= wd;
                        r_cnt      <= 4'(WAIT_CYCLES);
                        r_state    <= WAIT;
                    end else begin
                        r_state    <= IDLE;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_ready <= 1'b1;
                        r_err   <= w_err;
                        r_rd    <= (w_err || r_memwrite) ? 32'h0 : w_load;
                        r_state <= RESP;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign rd    = r_rd;
    assign err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=256, WAIT_CYCLES=2).
// Expected values are hand-computed; the misalignment case follows
// DMEM_ALIGN_CHECK_EN if the build defines it.
module tb_dmem_responder;

    localparam int WC  = 2;
    localparam int LAT = WC + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        memwrite;
    logic [2:0]  funct3;
    logic [31:0] aluout;
    logic [31:0] wd;
    logic        ready;
    logic [31:0] rd;
    logic        err;

    int total = 0;
    int bad   = 0;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .req(req), .memwrite(memwrite),
        .funct3(funct3), .aluout(aluout), .wd(wd),
        .ready(ready), .rd(rd), .err(err)
    );

    always #5 clk = ~clk;

    // Issue one request, wait (bounded) for ready, return latency in edges.
    task automatic do_req(input logic mw, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] r, output logic e);
        memwrite = mw; funct3 = f3; aluout = a; wd = d; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = i;
                break;
            end
        end
        r = rd;
        e = err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b0; memwrite = 1'b0; funct3 = 3'b010; aluout = 0; wd = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        total++;
        if (ready !== 1'b0 || err !== 1'b0 || rd !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: got ready=%b err=%b rd=%h want 0 0 00000000", ready, err, rd);
        end
    endtask

    task automatic test_word;
        int lat; logic [31:0] r; logic e;
        do_req(1'b1, 3'b010, 32'h0, 32'hAABBCCDD, lat, r, e);
        total++;
        if (lat !== LAT) begin bad++; $display("FAIL sw_latency: got %0d want %0d", lat, LAT); end
        total++;
        if (r !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL sw_resp: got rd=%h err=%b want 00000000 0", r, e); end
        do_req(1'b0, 3'b010, 32'h0, 32'h0, lat, r, e);
        total++;
        if (lat !== LAT) begin bad++; $display("FAIL lw_latency: got %0d want %0d", lat, LAT); end
        total++;
        if (r !== 32'hAABBCCDD || e !== 1'b0) begin bad++; $display("FAIL lw0: got rd=%h err=%b want aabbccdd 0", r, e); end
        // rd/err hold while idle
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (rd !== 32'hAABBCCDD || ready !== 1'b0) begin bad++; $display("FAIL rd_hold: got rd=%h ready=%b want aabbccdd 0", rd, ready); end
    endtask

    task automatic test_byte;
        int lat; logic [31:0] r; logic e;
        do_req(1'b1, 3'b010, 32'h4, 32'h0, lat, r, e);
        do_req(1'b1, 3'b000, 32'h5, 32'h00000080, lat, r, e);
        do_req(1'b0, 3'b000, 32'h5, 32'h0, lat, r, e);
        total++;
        if (r !== 32'hFFFFFF80) begin bad++; $display("FAIL lb5: got %h want ffffff80", r); end
        do_req(1'b0, 3'b100, 32'h5, 32'h0, lat, r, e);
        total++;
        if (r !== 32'h00000080) begin bad++; $display("FAIL lbu5: got %h want 00000080", r); end
        do_req(1'b0, 3'b010, 32'h4, 32'h0, lat, r, e);
        total++;
        if (r !== 32'h00008000) begin bad++; $display("FAIL lw4: got %h want 00008000", r); end
    endtask

    task automatic test_half;
        int lat; logic [31:0] r; logic e;
        do_req(1'b1, 3'b001, 32'h2, 32'h00001234, lat, r, e);
        do_req(1'b0, 3'b010, 32'h0, 32'h0, lat, r, e);
        total++;
        if (r !== 32'h1234CCDD) begin bad++; $display("FAIL sh_lw0: got %h want 1234ccdd", r); end
        do_req(1'b0, 3'b001, 32'h2, 32'h0, lat, r, e);
        total++;
        if (r !== 32'h00001234) begin bad++; $display("FAIL lh2: got %h want 00001234", r); end
        do_req(1'b0, 3'b001, 32'h0, 32'h0, lat, r, e);
        total++;
        if (r !== 32'hFFFFCCDD) begin bad++; $display("FAIL lh0: got %h want ffffccdd", r); end
        do_req(1'b0, 3'b101, 32'h0, 32'h0, lat, r, e);
        total++;
        if (r !== 32'h0000CCDD) begin bad++; $display("FAIL lhu0: got %h want 0000ccdd", r); end
    endtask

    task automatic test_align;
        int lat; logic [31:0] r; logic e;
        logic [31:0] exp_r; logic exp_e;
`ifdef DMEM_ALIGN_CHECK_EN
        exp_r = 32'h0;        exp_e = 1'b1;
`else
        exp_r = 32'h1234CCDD; exp_e = 1'b0;
`endif
        do_req(1'b0, 3'b010, 32'h2, 32'h0, lat, r, e);
        total++;
        if (r !== exp_r || e !== exp_e) begin bad++; $display("FAIL lw2_align: got rd=%h err=%b want %h %b", r, e, exp_r, exp_e); end
    endtask

    task automatic test_errors;
        int lat; logic [31:0] r; logic e;
        do_req(1'b1, 3'b010, 32'h400, 32'hDEADBEEF, lat, r, e);
        total++;
        if (e !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL sw_range: got err=%b rd=%h want 1 00000000", e, r); end
        do_req(1'b0, 3'b010, 32'h0, 32'h0, lat, r, e);
        total++;
        if (r !== 32'h1234CCDD || e !== 1'b0) begin bad++; $display("FAIL lw0_after_range: got rd=%h err=%b want 1234ccdd 0", r, e); end
        do_req(1'b0, 3'b011, 32'h0, 32'h0, lat, r, e);
        total++;
        if (e !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL f3_011: got err=%b rd=%h want 1 00000000", e, r); end
        do_req(1'b1, 3'b100, 32'h0, 32'hFFFFFFFF, lat, r, e);
        total++;
        if (e !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL store_f3_100: got err=%b rd=%h want 1 00000000", e, r); end
        do_req(1'b0, 3'b010, 32'h0, 32'h0, lat, r, e);
        total++;
        if (r !== 32'h1234CCDD) begin bad++; $display("FAIL lw0_after_illegal: got %h want 1234ccdd", r); end
        do_req(1'b0, 3'b010, 32'h3FC, 32'h0, lat, r, e);
        total++;
        if (e !== 1'b0) begin bad++; $display("FAIL last_word_range: got err=%b want 0", e); end
    endtask

    task automatic test_back_to_back;
        int lat;
        memwrite = 1'b0; funct3 = 3'b010; aluout = 32'h0; wd = 0; req = 1'b1;
        @(posedge clk); #1;
        aluout = 32'h4;  // ignored while the first request is waiting
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready) begin lat = i; break; end
        end
        total++;
        if (lat !== LAT || rd !== 32'h1234CCDD) begin bad++; $display("FAIL b2b_first: got lat=%0d rd=%h want %0d 1234ccdd", lat, rd, LAT); end
        @(posedge clk); #1;  // req still high: accepted at the RESP edge
        req = 1'b0;
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL b2b_pulse_width: got ready=%b want 0", ready); end
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready) begin lat = i; break; end
        end
        total++;
        if (lat !== LAT || rd !== 32'h00008000) begin bad++; $display("FAIL b2b_second: got lat=%0d rd=%h want %0d 00008000", lat, rd, LAT); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] r; logic e; int seen;
        do_req(1'b1, 3'b010, 32'h8, 32'hCAFEF00D, lat, r, e);
        do_req(1'b0, 3'b010, 32'h8, 32'h0, lat, r, e);
        total++;
        if (r !== 32'hCAFEF00D) begin bad++; $display("FAIL lw8_prior: got %h want cafef00d", r); end
        memwrite = 1'b1; funct3 = 3'b010; aluout = 32'h8; wd = 32'h11111111; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (ready !== 1'b0 || rd !== 32'h0 || err !== 1'b0) begin bad++; $display("FAIL reset_mid_outputs: got ready=%b rd=%h err=%b want 0 00000000 0", ready, rd, err); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL reset_mid_no_ready: got %0d pulses want 0", seen); end
        do_req(1'b0, 3'b010, 32'h8, 32'h0, lat, r, e);
        total++;
        if (r !== 32'hCAFEF00D) begin bad++; $display("FAIL lw8_after_reset: got %h want cafef00d", r); end
    endtask

    initial begin
        test_reset;
        test_word;
        test_byte;
        test_half;
        test_align;
        test_errors;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
